// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: resolves E0/F0 prefixes, filters typematic
// repeats, tracks the 13 held piano keys and the octave register.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned OCT_MAX        = 6,
    parameter int unsigned OCT_INIT       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_data,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_ext,
    output logic        key_break,
    output logic        key_repeat,
    output logic [12:0] note_held,
    output logic        note_active,
    output logic [3:0]  note_idx,
    output logic [2:0]  octave
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          z_held, x_held;

    logic          emit, ev_ext, ev_brk;
    logic [12:0]   held_next;
    logic          z_next, x_next, rep_next;
    logic [2:0]    oct_next;
    logic [3:0]    idx_next;
    logic [4:0]    lookup;

    // {hit, index} for the piano key map
    function automatic logic [4:0] note_lookup(input logic [7:0] b);
        case (b)
            8'h1C:   return {1'b1, 4'd0};
            8'h1D:   return {1'b1, 4'd1};
            8'h1B:   return {1'b1, 4'd2};
            8'h24:   return {1'b1, 4'd3};
            8'h23:   return {1'b1, 4'd4};
            8'h2B:   return {1'b1, 4'd5};
            8'h2C:   return {1'b1, 4'd6};
            8'h34:   return {1'b1, 4'd7};
            8'h35:   return {1'b1, 4'd8};
            8'h33:   return {1'b1, 4'd9};
            8'h3C:   return {1'b1, 4'd10};
            8'h3B:   return {1'b1, 4'd11};
            8'h42:   return {1'b1, 4'd12};
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_data == 8'hE0)      state_next = EXT;
                else if (rx_data == 8'hF0) state_next = BRK;
                else                       emit = 1'b1;
            end
            EXT: begin
                if (rx_data == 8'hF0)      state_next = EXT_BRK;
                else if (rx_data != 8'hE0) begin
                    emit = 1'b1; ev_ext = 1'b1; state_next = IDLE;
                end
            end
            BRK: begin
                if (rx_data == 8'hE0)      state_next = EXT_BRK;
                else if (rx_data != 8'hF0) begin
                    emit = 1'b1; ev_brk = 1'b1; state_next = IDLE;
                end
            end
            default: begin
                if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                    emit = 1'b1; ev_ext = 1'b1; ev_brk = 1'b1; state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        lookup    = note_lookup(rx_data);
        held_next = note_held;
        z_next    = z_held;
        x_next    = x_held;
        oct_next  = octave;
        rep_next  = 1'b0;
        if (rx_done_tick && emit && !ev_ext) begin
            if (state == IDLE && (rx_data == 8'hAA || rx_data == 8'hFC)) begin
                held_next = '0;
                z_next    = 1'b0;
                x_next    = 1'b0;
            end else if (lookup[4]) begin
                if (ev_brk)                    held_next[lookup[3:0]] = 1'b0;
                else if (note_held[lookup[3:0]]) rep_next = 1'b1;
                else                           held_next[lookup[3:0]] = 1'b1;
            end else if (rx_data == 8'h1A) begin
                if (ev_brk)      z_next = 1'b0;
                else if (z_held) rep_next = 1'b1;
                else begin
                    z_next = 1'b1;
                    if (octave > 3'd0) oct_next = octave - 3'd1;
                end
            end else if (rx_data == 8'h22) begin
                if (ev_brk)      x_next = 1'b0;
                else if (x_held) rep_next = 1'b1;
                else begin
                    x_next = 1'b1;
                    if (octave < 3'(OCT_MAX)) oct_next = octave + 3'd1;
                end
            end
        end
    end

    // Lowest held index wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        idx_next = '0;
        for (int unsigned i = 13; i > 0; i--) begin
            if (held_next[i-1]) idx_next = 4'(i - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_break   <= 1'b0;
            key_repeat  <= 1'b0;
            note_held   <= '0;
            note_active <= 1'b0;
            note_idx    <= '0;
            octave      <= 3'(OCT_INIT);
            z_held      <= 1'b0;
            x_held      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (rx_done_tick) begin
                // A byte arriving on the timeout cycle is still decoded in the prefix state.
                cnt   <= '0;
                state <= state_next;
                if (emit) begin
                    key_valid  <= 1'b1;
                    key_code   <= rx_data;
                    key_ext    <= ev_ext;
                    key_break  <= ev_brk;
                    key_repeat <= rep_next;
                end
            end else if (state != IDLE) begin
                if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            note_held   <= held_next;
            note_active <= |held_next;
            note_idx    <= idx_next;
            octave      <= oct_next;
            z_held      <= z_next;
            x_held      <= x_next;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed plus random byte streams against a prefix-flag reference model.
module tb_ps2_key_decoder;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        key_valid, key_ext, key_break, key_repeat, note_active;
    logic [7:0]  key_code;
    logic [12:0] note_held;
    logic [3:0]  note_idx;
    logic [2:0]  octave;

    int checks = 0;
    int errors = 0;

    logic [7:0] note_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                    8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

    // reference model: pending-prefix flags plus held sets
    bit          m_ext, m_brk, m_z, m_x;
    bit [12:0]   m_held;
    int          m_oct;
    logic [7:0]  e_code;
    bit          e_ext, e_brk, e_rep;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .OCT_MAX(6), .OCT_INIT(4)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_break(key_break), .key_repeat(key_repeat), .note_held(note_held),
        .note_active(note_active), .note_idx(note_idx), .octave(octave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 13; i++) if (note_codes[i] == b) return i;
        return -1;
    endfunction

    function automatic int lowest(input bit [12:0] h);
        for (int i = 0; i < 13; i++) if (h[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_z = 0; m_x = 0; m_held = '0; m_oct = 4;
        e_code = '0; e_ext = 0; e_brk = 0; e_rep = 0;
    endtask

    task automatic check_state(input string tag, input bit exp_valid);
        chk({tag, ".valid"}, 32'(key_valid), 32'(exp_valid));
        chk({tag, ".code"}, 32'(key_code), 32'(e_code));
        chk({tag, ".ext"}, 32'(key_ext), 32'(e_ext));
        chk({tag, ".brk"}, 32'(key_break), 32'(e_brk));
        chk({tag, ".rep"}, 32'(key_repeat), 32'(e_rep));
        chk({tag, ".held"}, 32'(note_held), 32'(m_held));
        chk({tag, ".active"}, 32'(note_active), 32'(m_held != 0));
        chk({tag, ".idx"}, 32'(note_idx), 32'(lowest(m_held)));
        chk({tag, ".oct"}, 32'(octave), 32'(m_oct));
    endtask

    // idle = empty cycles before the strobe; gap between strobes is idle+1 edges
    task automatic send(input logic [7:0] b, input int unsigned idle, input string tag);
        bit ev;
        int n;
        for (int unsigned k = 0; k < idle; k++) begin
            @(negedge clk);
            chk({tag, ".idle_valid"}, 32'(key_valid), 32'd0);
        end
        if ((m_ext || m_brk) && (idle + 1 > TO)) begin
            m_ext = 0; m_brk = 0;
        end
        ev = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            ev = 1;
            e_code = b; e_ext = m_ext; e_brk = m_brk; e_rep = 0;
            n = note_of(b);
            if (!m_ext) begin
                if (!m_brk && (b == 8'hAA || b == 8'hFC)) begin
                    m_held = '0; m_z = 0; m_x = 0;
                end else if (n >= 0) begin
                    if (m_brk) m_held[n] = 0;
                    else if (m_held[n]) e_rep = 1;
                    else m_held[n] = 1;
                end else if (b == 8'h1A) begin
                    if (m_brk) m_z = 0;
                    else if (m_z) e_rep = 1;
                    else begin m_z = 1; if (m_oct > 0) m_oct--; end
                end else if (b == 8'h22) begin
                    if (m_brk) m_x = 0;
                    else if (m_x) e_rep = 1;
                    else begin m_x = 1; if (m_oct < 6) m_oct++; end
                end
            end
            m_ext = 0; m_brk = 0;
        end
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        check_state(tag, ev);
    endtask

    initial begin
        logic [7:0] b;
        int unsigned r, idle;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset", 0);
        reset = 1'b0;

        // make/break of A
        send(8'h1C, 0, "a_make");
        chk("a_make.held_const", 32'(note_held), 32'h0001);
        send(8'hF0, 1, "a_f0");
        send(8'h1C, 0, "a_break");
        chk("a_break.active_const", 32'(note_active), 32'd0);

        // chord with typematic repeat
        send(8'h23, 2, "chord1");
        send(8'h42, 0, "chord2");
        chk("chord2.held_const", 32'(note_held), 32'h1010);
        send(8'h23, 3, "chord_rep");
        chk("chord_rep.rep_const", 32'(key_repeat), 32'd1);
        send(8'hF0, 0, "chord_f0");
        send(8'h23, 0, "chord_brk");
        chk("chord_brk.idx_const", 32'(note_idx), 32'd12);
        send(8'hF0, 0, "chord_f0b");
        send(8'h42, 0, "chord_brk2");

        // extended sequences
        send(8'hE0, 1, "ext_e0");
        send(8'h75, 0, "ext_make");
        send(8'hE0, 1, "extb_e0");
        send(8'hF0, 0, "extb_f0");
        send(8'h75, 0, "ext_brk");
        chk("ext_brk.ext_const", 32'(key_ext), 32'd1);

        // octave saturation
        for (int i = 0; i < 3; i++) begin
            send(8'h22, 1, "oct_up");
            send(8'hF0, 0, "oct_up_f0");
            send(8'h22, 0, "oct_up_brk");
        end
        chk("oct_sat_const", 32'(octave), 32'd6);
        send(8'h1A, 1, "oct_dn");
        send(8'h1A, 1, "oct_dn_rep");
        send(8'hF0, 0, "oct_dn_f0");
        send(8'h1A, 0, "oct_dn_brk");
        chk("oct_dn_const", 32'(octave), 32'd5);

        // timeout: abandoned prefix, then boundary gaps TO (kept) and TO+1 (dropped)
        send(8'hF0, 0, "to_f0");
        send(8'h1C, 20, "to_make");
        chk("to_make.brk_const", 32'(key_break), 32'd0);
        send(8'hF0, 0, "to_f0b");
        send(8'h1C, 10, "to_brk");
        send(8'hF0, 0, "to_f0c");
        send(8'h1D, TO - 1, "to_edge_keep");
        send(8'hF0, 0, "to_f0d");
        send(8'h1D, TO, "to_edge_drop");
        send(8'hAA, 0, "bat");

        // reset mid-sequence
        send(8'h1C, 0, "rst_hold");
        send(8'hF0, 0, "rst_f0");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #2;
        check_state("rst_async", 0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h1C, 0, "rst_after");
        chk("rst_after.brk_const", 32'(key_break), 32'd0);

        // randomized stream
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 70) b = note_codes[$urandom_range(0, 12)];
            else if (r < 82) b = r[0] ? 8'h1A : 8'h22;
            else if (r < 85) b = r[0] ? 8'hAA : 8'hFC;
            else             b = 8'($urandom);
            idle = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2)
                                                : $urandom_range(0, 2);
            send(b, idle, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream from the PS/2 receiver (`rx_done_tick` / `rx_data`) and turns PS/2 Set-2 scan-code sequences into key make/break events. It resolves the `E0` (extended) and `F0` (break) prefixes and filters typematic repeats. It keeps a held-state bitmap for the 13 piano keys and an octave register for the tone generator downstream.

## Interface
- `TIMEOUT_CYCLES`, default 2_500_000: clk cycles allowed between a prefix byte and the next byte before the sequence is abandoned (≈25 ms at 100 MHz).
- `OCT_MAX`, default 6: highest octave value.
- `OCT_INIT`, default 4: octave value after reset.
- `clk  in  1`: system clock.
- `reset  in  1`: asynchronous, active-high.
- `rx_done_tick  in  1`: one-cycle strobe, new byte on `rx_data`.
- `rx_data  in  8`: received scan-code byte, valid while `rx_done_tick`=1.
- `key_valid  out  1`: one-cycle pulse, complete key event.
- `key_code  out  8`: final (non-prefix) byte of the event.
- `key_ext  out  1`: event carried the `E0` prefix.
- `key_break  out  1`: event carried the `F0` prefix (release).
- `key_repeat  out  1`: make event for a note/octave key already held.
- `note_held  out  13`: bit i = piano key i currently held.
- `note_active  out  1`: `|note_held`.
- `note_idx  out  4`: lowest set index in `note_held`; 0 when none are held.
- `octave  out  3`: current octave, 0..OCT_MAX.

## Operation
- Key map, index 0..12 (C..C'): `1C` A, `1D` W, `1B` S, `24` E, `23` D, `2B` F, `2C` T, `34` G, `35` Y, `33` H, `3C` U, `3B` J, `42` K.
- Octave keys: `1A` Z = down, `22` X = up.
- Prefix FSM, which advances only on `rx_done_tick`:
  - IDLE: `E0`→EXT; `F0`→BRK; any other byte→emit make event, stay IDLE.
  - EXT: `F0`→EXT_BRK; `E0`→stay EXT; other→emit extended make, go IDLE.
  - BRK: `F0`→stay BRK; `E0`→EXT_BRK; other→emit break, go IDLE.
  - EXT_BRK: `E0`/`F0`→stay; other→emit extended break, go IDLE.
- Timeout counter:
  - Cleared on every `rx_done_tick`.
  - Counts while the state is not IDLE.
  - On reaching `TIMEOUT_CYCLES-1`, go IDLE with no event.
- Every emitted event asserts `key_valid`. Note and octave effects apply to non-extended events only. Extended events are reported and otherwise ignored.
- Mapped note make:
  - Bit clear → set the bit, `key_repeat`=0.
  - Bit set → no change, `key_repeat`=1.
- Mapped note break: clear the bit. Breaking a key that is not held is harmless.
- Z/X use internal held flags in the same way as notes.
  - First make (not a repeat): Z decrements `octave` if >0; X increments if <OCT_MAX. Otherwise `octave` saturates with no change.
  - Repeats do not change `octave`.
  - Break clears the flag.
- Byte `AA` (BAT OK) or `FC` received in IDLE: clear `note_held` and the Z/X flags. `key_valid` still pulses with `key_code` = the byte.
- Reset values:
  - FSM=IDLE, counter=0.
  - `key_valid`/`key_ext`/`key_break`/`key_repeat`=0, `key_code`=00.
  - `note_held`=0, `note_active`=0, `note_idx`=0.
  - `octave`=OCT_INIT, Z/X flags clear.
- Reset asserted mid-sequence discards the partial sequence. Any byte strobed during reset is lost.

## Timing
- All outputs registered.
- Latency: `key_valid`, `key_code`/`key_ext`/`key_break`/`key_repeat`, `note_held`, `note_active`, `note_idx` and `octave` all update on the clock edge that samples the final byte's `rx_done_tick`. They are visible in the following cycle.
- `note_active` and `note_idx` are computed from the next value of `note_held`, so they are never a cycle behind it.
- `key_code`/`key_ext`/`key_break`/`key_repeat` hold their value until the next event. Only `key_valid` is a pulse.
- Back-to-back `rx_done_tick` on consecutive cycles is legal, and each byte is processed in order.
- A timeout and an `rx_done_tick` in the same cycle: the byte wins. It is processed in the current state and the timeout is ignored.
- Two keys held then one released: `note_idx` moves to the remaining key in the same update.

## Test plan
- **Make/break of A:** bytes `1C`, `F0 1C` → first `key_valid` with code=1C, break=0, `note_held`=0x0001, `note_idx`=0, `note_active`=1. Second `key_valid` with break=1, `note_held`=0, `note_active`=0.
- **Chord plus typematic repeat:** bytes `23`, `42`, `23`, `F0 23` →
  - `note_held`=0x0010, then 0x1010.
  - Third event has `key_repeat`=1 and `note_held` unchanged.
  - After the break, `note_held`=0x1000 and `note_idx`=12.
- **Extended sequences:** bytes `E0 75`, `E0 F0 75` → two events with ext=1 (break=0, then break=1). `note_held` and `octave` are unchanged.
- **Octave saturation:** 3× (`22`, `F0 22`) from reset gives `octave` 5, 6, 6. Then `1A`, `1A` (repeat), `F0 1A` gives `octave`=5, and the second `1A` has `key_repeat`=1.
- **Timeout:** with `TIMEOUT_CYCLES`=16, send `F0`, wait 20 cycles, send `1C` → a make event (break=0) and `note_held`=0x0001. Then send `F0`, wait 10 cycles, send `1C` → a break event.
- **Reset mid-sequence:** hold A, send `F0`, pulse reset, then send `1C` → outputs return to their reset values during reset. After reset the event is a make, `note_held`=0x0001, `octave`=4.
